// File: rtl/reaction_timer.sv
// +------------------------------------------------------------------------+
// | Module   : reaction_timer                                              |
// | Brief    : reaction-time game controller (random wait, GO lamp, timing) |
// |            Optional best-time tracking with macro REACTION_BEST_EN.    |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module reaction_timer #(
   parameter int CLKS_PER_MS  = 50000,
   parameter int MAX_REACT_MS = 9999,
   parameter int RAND_WAIT    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        react,
   input  logic [12:0] rand_num,
   output logic        new_rand,
   output logic        led_go,
   output logic        busy,
   output logic [13:0] react_ms,
   output logic        result_valid,
   output logic        false_start,
   output logic        timeout,
   output logic [13:0] best_ms
);

   localparam int c_TICK_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam int c_WAIT_W = (RAND_WAIT > 1) ? $clog2(RAND_WAIT) : 1;
   localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(CLKS_PER_MS - 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(RAND_WAIT - 1);
   localparam logic [13:0]         c_MAX_MS    = 14'(MAX_REACT_MS);
   localparam logic [12:0]         c_MIN_DLY   = 13'd500;
   localparam logic [12:0]         c_MAX_DLY   = 13'd5000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_LOAD  = 3'd2,
      S_DELAY = 3'd3,
      S_GO    = 3'd4,
      S_DONE  = 3'd5,
      S_FOUL  = 3'd6
   } state_t;

   state_t               r_state;
   logic                 r_start_prev;
   logic                 r_react_prev;
   logic [c_TICK_W-1:0]  r_tick;
   logic [13:0]          r_ms;
   logic [c_WAIT_W-1:0]  r_wait;
   logic [12:0]          r_delay;
   logic                 r_new_rand;
   logic                 r_led_go;
   logic                 r_busy;
   logic                 r_valid;
   logic                 r_false;
   logic                 r_timeout;
   logic [13:0]          r_react_ms;

   logic                 w_start_edge;
   logic                 w_react_edge;
   logic                 w_tick_wrap;
   logic [13:0]          w_ms_next;
   logic                 w_delay_hit;
   logic                 w_max_hit;
   logic [12:0]          w_delay_clamp;

   assign w_start_edge  = start & ~r_start_prev;
   assign w_react_edge  = react & ~r_react_prev;
   assign w_tick_wrap   = (r_tick == c_TICK_LAST);
   assign w_ms_next     = r_ms + 14'd1;
   // Look one tick ahead so the transition lands on the edge where ms_cnt would reach the target.
   assign w_delay_hit   = w_tick_wrap && (w_ms_next == {1'b0, r_delay});
   assign w_max_hit     = w_tick_wrap && (w_ms_next == c_MAX_MS);
   assign w_delay_clamp = (rand_num < c_MIN_DLY) ? c_MIN_DLY :
                          (rand_num > c_MAX_DLY) ? c_MAX_DLY : rand_num;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_start_prev <= 1'b0;
         r_react_prev <= 1'b0;
         r_tick       <= '0;
         r_ms         <= '0;
         r_wait       <= '0;
         r_delay      <= '0;
         r_new_rand   <= 1'b0;
         r_led_go     <= 1'b0;
         r_busy       <= 1'b0;
         r_valid      <= 1'b0;
         r_false      <= 1'b0;
         r_timeout    <= 1'b0;
         r_react_ms   <= '0;
      end else begin
         r_start_prev <= start;
         r_react_prev <= react;

         if (r_state == S_DELAY || r_state == S_GO) begin
            r_tick <= w_tick_wrap ? '0 : r_tick + c_TICK_W'(1);
            if (w_tick_wrap) begin
               r_ms <= w_ms_next;
            end
         end else begin
            r_tick <= '0;
            r_ms   <= '0;
         end

         case (r_state)
            S_IDLE, S_DONE, S_FOUL: begin
               if (w_start_edge) begin
                  r_state    <= S_REQ;
                  r_new_rand <= 1'b1;
                  r_busy     <= 1'b1;
                  r_valid    <= 1'b0;
                  r_false    <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_react_ms <= '0;
               end
            end
            S_REQ: begin
               r_new_rand <= 1'b0;
               r_wait     <= '0;
               r_state    <= S_LOAD;
            end
            S_LOAD: begin
               if (r_wait == c_WAIT_LAST) begin
                  r_delay <= w_delay_clamp;
                  r_state <= S_DELAY;
               end else begin
                  r_wait <= r_wait + c_WAIT_W'(1);
               end
            end
            S_DELAY: begin
               if (w_react_edge) begin
                  r_false <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_FOUL;
               end else if (w_delay_hit) begin
                  r_led_go <= 1'b1;
                  r_tick   <= '0;
                  r_ms     <= '0;
                  r_state  <= S_GO;
               end
            end
            S_GO: begin
               if (w_react_edge) begin
                  r_react_ms <= r_ms;
                  r_valid    <= 1'b1;
                  r_led_go   <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= S_DONE;
               end else if (w_max_hit) begin
                  r_react_ms <= c_MAX_MS;
                  r_timeout  <= 1'b1;
                  r_led_go   <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign new_rand     = r_new_rand;
   assign led_go       = r_led_go;
   assign busy         = r_busy;
   assign react_ms     = r_react_ms;
   assign result_valid = r_valid;
   assign false_start  = r_false;
   assign timeout      = r_timeout;

`ifdef REACTION_BEST_EN
   logic        r_best;
   logic [13:0] r_best_ms;
   logic        w_react_hit;

   assign w_react_hit = (r_state == S_GO) && w_react_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_best_ms <= 14'd9999;
         r_best    <= 1'b0;
      end else begin
         r_best <= w_react_hit;
         if (w_react_hit && (r_ms < r_best_ms)) begin
            r_best_ms <= r_ms;
         end
      end
   end

   assign best_ms = r_best_ms;
`else
   assign best_ms = 14'd0;
`endif

endmodule

`default_nettype wire

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Reaction-time game controller; sits directly downstream of the random-delay generator.
- Requests a fresh random value (500..5000) over the generator's `new` rising-edge interface and uses it as the wait delay in ms.
- Lights the GO lamp after that delay and measures the player's reaction in ms.
- Flags false starts and timeouts; results feed the display/scoring logic.

Parameters:
- CLKS_PER_MS, 50000: clock cycles per millisecond tick (50 MHz system clock).
- MAX_REACT_MS, 9999: reaction count saturation/timeout value (fits 14 bits).
- RAND_WAIT, 2: cycles between the new_rand rising edge and sampling rand_num (covers the generator's registered capture).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  synchronised start button, level; rising edge used.
- react  input  1  synchronised reaction button, level; rising edge used.
- rand_num  input  13  random delay in ms from the generator, range 500..5000.
- new_rand  output  1  request to the generator; driven into its `new` input.
- led_go  output  1  GO lamp.
- busy  output  1  high in REQ, LOAD, DELAY and GO.
- react_ms  output  14  measured reaction time in ms.
- result_valid  output  1  high while react_ms holds a valid result.
- false_start  output  1  high after react is pressed before GO.
- timeout  output  1  high when no react arrives within MAX_REACT_MS.
- best_ms  output  14  best (minimum) valid reaction time; see Optional Feature.

Behaviour:
- Reset (async, any time, including mid-game):
  - state=IDLE.
  - All outputs 0, except best_ms=14'd9999.
  - Edge-detect registers, tick and ms counters cleared.
- Edge detect: each button has a registered previous sample; an edge is `cur & ~prev`. Internal decision latency is 1 cycle after the input rises.
- Tick generator:
  - tick_cnt counts 0..CLKS_PER_MS-1 and cleared on entry to DELAY and GO.
  - ms_cnt (14 bit) increments when tick_cnt wraps; cleared on entry to DELAY and GO.
- States:
  - IDLE: on start edge, go to REQ. Clear result_valid, false_start, timeout and react_ms.
  - REQ: new_rand=1 for exactly 1 cycle, then go to LOAD.
  - LOAD: wait RAND_WAIT cycles with new_rand=0, then latch delay_ms=rand_num and go to DELAY.
    - If the latched value is outside 500..5000, clamp: <500 becomes 500, >5000 becomes 5000.
  - DELAY:
    - react edge: go to FOUL (false_start=1, led_go stays 0).
    - Otherwise, when ms_cnt reaches delay_ms: go to GO and set led_go=1. This happens exactly delay_ms*CLKS_PER_MS cycles after DELAY entry.
    - start edge is ignored.
  - GO:
    - react edge: react_ms=ms_cnt (completed ms, floored), result_valid=1, led_go=0, go to DONE.
    - ms_cnt reaches MAX_REACT_MS without react: react_ms=MAX_REACT_MS, timeout=1, led_go=0, go to DONE.
    - react edge and timeout in the same cycle: react wins.
  - DONE / FOUL: hold all results. On start edge, clear the flags and go to REQ (new round).
- Simultaneous start and react edges:
  - In IDLE/DONE/FOUL, start wins and react is ignored.
  - In DELAY, react wins.
- A level-held react from a previous round does not trigger a new edge.
- new_rand is never high outside REQ.

Optional Feature:
- Macro: REACTION_BEST_EN.
- Defined:
  - On each transition GO→DONE with result_valid, if react_ms < best_ms then best_ms <= react_ms.
  - Timeouts and false starts never update best_ms.
  - best_ms is cleared to 9999 only by rst.
- Undefined: best_ms is tied to 14'd0 and no comparator or register is built.

Test Plan (CLKS_PER_MS=10, RAND_WAIT=2, generator model returns rand_num=600):
- Normal round:
  - Stimulus: rst pulse, then start edge; react edge 1234 cycles after led_go rises.
  - Response: new_rand pulses exactly 1 cycle; led_go rises 6000 cycles after DELAY entry; react_ms=123, result_valid=1.
- False start:
  - Stimulus: start, then react edge 3000 cycles into DELAY.
  - Response: false_start=1, led_go never rises, result_valid=0, state FOUL until next start.
- Timeout:
  - Stimulus: start, no react.
  - Response: led_go falls after 99990 cycles of GO; react_ms=9999, timeout=1.
- Clamp:
  - Stimulus: rand_num=100 for one round, then 7000 for the next.
  - Response: led_go rises after 5000 cycles, then after 50000 cycles.
- Async reset mid-DELAY:
  - Stimulus: assert rst asynchronously (between clock edges).
  - Response: all outputs zero immediately and no GO afterwards. With REACTION_BEST_EN, best_ms=9999.
- Best time (REACTION_BEST_EN):
  - Stimulus: rounds with reactions of 300, 200 and 250 ms.
  - Response: best_ms = 300, then 200, then stays 200. A false-start round leaves best_ms unchanged.
